izh_param_serializer: RTL and testbench
=======================================

# izh_param_serializer

Serial transmitter for the Izhikevich neuron parameter-load interface. Latches four 6-bit parameters (a, b, c, d) and shifts them out as one 24-bit frame on `serial_data` while driving `load_mode` high: the exact stream the on-chip parameter loader consumes. It sits in the host-side or test-harness controller and drives the `load_mode`/`serial_data` pins of the neuron system.

## Interface
Parameters:
- `PARAM_W`, 6: width of each parameter.
- `NUM_PARAMS`, 4: parameters per frame. Frame length is `PARAM_W*NUM_PARAMS` = 24 bits.
- `BIT_CYCLES`, 1: enabled clock cycles each bit is held (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: global clock-enable; low freezes all state and outputs.
- `start` in 1: request to send a frame; sampled only while `ready`=1 and `enable`=1.
- `param_a` in 6: parameter a, transmitted first.
- `param_b` in 6: parameter b.
- `param_c` in 6: parameter c.
- `param_d` in 6: parameter d, transmitted last.
- `ready` out 1: idle, able to accept `start`.
- `load_mode` out 1: frame-valid strobe to the loader; high for exactly 24·`BIT_CYCLES` enabled cycles per frame.
- `serial_data` out 1: current bit, MSB-first within each parameter.
- `done` out 1: one-cycle pulse after the last bit.

## Operation
- States: IDLE, SHIFT.
- IDLE: `ready`=1, `load_mode`=0, `serial_data`=0. If `enable`=1 and `start`=1, load the 24-bit shift register with {a,b,c,d}, clear the bit counter and period counter, and go to SHIFT.
- SHIFT: `ready`=0, `load_mode`=1, `serial_data`=shreg[23]. The period counter counts 0..`BIT_CYCLES`-1. At terminal count, shift left by 1 (zero fill) and increment the bit counter (0..23).
- After the terminal count of bit 23, go to IDLE. `done`=1 for that first IDLE cycle only.
- Inputs `param_*` are sampled only at the accepting edge. Later changes do not affect the frame in flight.
- `start` while in SHIFT is ignored and not queued.
- `start` accepted in the `done` cycle is legal. `load_mode` is then low for exactly one cycle between frames, which guarantees a frame boundary.
- `enable`=0: the state, counters, shift register and all outputs hold. A one-cycle `done` pulse that coincides with `enable`=0 stays high until the next enabled cycle, then drops.
- Bit counter is 5 bits. Period counter is `$clog2(BIT_CYCLES)` bits, minimum 1. No wrap beyond the terminal values.

## Timing
- Reset values: state IDLE, `ready`=1, `load_mode`=0, `serial_data`=0, `done`=0, shreg=0.
- `reset` mid-frame: the next edge forces the reset values. A partial frame is abandoned with `load_mode` dropping, and no `done` is generated.
- Latency: `start` sampled at edge 0. `load_mode`=1 and `serial_data`=a[5] are registered outputs visible after edge 0.
- Bit k is valid for enabled cycles k·`BIT_CYCLES` .. (k+1)·`BIT_CYCLES`−1 after edge 0.
- `done`/`ready` rise 24·`BIT_CYCLES` enabled cycles after edge 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `izh_pkg`:
  - `PARAM_W`=6, `NUM_PARAMS`=4, `FRAME_BITS`=24.
  - State enum `ser_state_t` {IDLE, SHIFT}.
  - The parameter ordering constant (a,b,c,d, MSB-first), shared with the loader.
- One sub-module: `izh_bit_timer`, the `BIT_CYCLES` prescaler with `enable`, emitting a `bit_tick` pulse. The shift FSM stays in the top module.

## Test plan
- Reset then `start` with a=0x2A, b=0x15, c=0x3F, d=0x00, `BIT_CYCLES`=1:
  - serial stream 101010_010101_111111_000000;
  - `load_mode` high for exactly 24 cycles;
  - `done` one cycle;
  - `ready` back.
- `BIT_CYCLES`=3, a=0x01, other parameters 0: each bit held 3 cycles, bit 5 is 1, `load_mode` high for 72 cycles.
- `start` pulsed during SHIFT, and `param_*` changed mid-frame: the frame content is unchanged, and exactly one `done` occurs.
- Back-to-back with `start` held high: `load_mode` low exactly 1 cycle between frames, and the second frame is correct.
- `enable` low for 5 cycles at bit 10: outputs frozen, the stream resumes without loss, and `done` is delayed by 5 cycles.
- `reset` asserted at bit 12: the next cycle shows `load_mode`=0, `ready`=1, no `done`. A fresh `start` sends a full correct frame.

Source files
------------

// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich parameter-load link: frame geometry,
// serializer state encoding and the slot order the on-chip loader expects.
package izh_pkg;

   localparam int PARAM_W    = 6;
   localparam int NUM_PARAMS = 4;
   localparam int FRAME_BITS = PARAM_W * NUM_PARAMS;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // Slot order on the wire: a leaves first, d last, each parameter MSB-first.
   typedef enum logic [1:0] {
      PARAM_A = 2'd0,
      PARAM_B = 2'd1,
      PARAM_C = 2'd2,
      PARAM_D = 2'd3
   } param_slot_t;

   localparam bit MSB_FIRST = 1'b1;

   function automatic int slot_msb(input param_slot_t slot);
      return FRAME_BITS - 1 - int'(slot) * PARAM_W;
   endfunction

endpackage

// File: rtl/izh_bit_timer.sv
// Bit-period prescaler: while running, emits one bit_tick every BIT_CYCLES
// enabled cycles; held at zero when idle so every frame starts a fresh period.
module izh_bit_timer #(
   parameter int BIT_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic i_run,
   output logic o_bit_tick
);

   localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_bit_tick = enable & i_run & (r_cnt == LAST_CNT);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (enable) begin
         if (!i_run || o_bit_tick) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/izh_param_serializer.sv
// Shifts {a,b,c,d} out MSB-first as one frame on serial_data with load_mode
// framing it; done pulses once in the first idle cycle after the last bit.
module izh_param_serializer
   import izh_pkg::*;
#(
   parameter int PARAM_W    = izh_pkg::PARAM_W,
   parameter int NUM_PARAMS = izh_pkg::NUM_PARAMS,
   parameter int BIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               start,
   input  logic [PARAM_W-1:0] param_a,
   input  logic [PARAM_W-1:0] param_b,
   input  logic [PARAM_W-1:0] param_c,
   input  logic [PARAM_W-1:0] param_d,
   output logic               ready,
   output logic               load_mode,
   output logic               serial_data,
   output logic               done
);

   localparam int          FRAME_LEN = PARAM_W * NUM_PARAMS;
   localparam logic [4:0]  LAST_BIT  = 5'(FRAME_LEN - 1);

   ser_state_t             r_state;
   logic [FRAME_LEN-1:0]   r_shreg;
   logic [4:0]             r_bit_cnt;
   logic                   r_done;
   logic                   w_bit_tick;

   izh_bit_timer #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_bit_timer (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .i_run     (r_state == SHIFT),
      .o_bit_tick(w_bit_tick)
   );

   // NOTE: the shift register is a plain datapath register but is reset too, so serial_data idles low.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_done    <= 1'b0;
      end else if (enable) begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_shreg   <= {param_a, param_b, param_c, param_d};
                  r_bit_cnt <= '0;
                  r_state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_bit_tick) begin
                  // Zero fill leaves the register clear once the last bit has gone.
                  r_shreg <= {r_shreg[FRAME_LEN-2:0], 1'b0};
                  if (r_bit_cnt == LAST_BIT) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ready       = (r_state == IDLE);
   assign load_mode   = (r_state == SHIFT);
   assign serial_data = r_shreg[FRAME_LEN-1];
   assign done        = r_done;

endmodule

// File: tb/tb_izh_param_serializer.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor rebuilds
// each frame from the pins of a BIT_CYCLES=1 and a BIT_CYCLES=3 instance.
module tb_izh_param_serializer;

   typedef struct {
      logic [23:0] frame;
      bit          abort;
      bit          b2b;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, enable, start_1, start_3;
   logic [5:0] pa, pb, pc, pd;
   logic       ready_1, lm_1, sd_1, done_1;
   logic       ready_3, lm_3, sd_3, done_3;

   int total = 0;
   int bad   = 0;
   bit mon_on = 1'b0;

   exp_t sbq[2][$];
   bit   bq[2][$];
   bit   in_frame[2];
   int   gap[2];
   int   done_cnt[2];

   always #5 clk = ~clk;

   izh_param_serializer #(.BIT_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset), .enable(enable), .start(start_1),
      .param_a(pa), .param_b(pb), .param_c(pc), .param_d(pd),
      .ready(ready_1), .load_mode(lm_1), .serial_data(sd_1), .done(done_1)
   );

   izh_param_serializer #(.BIT_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset), .enable(enable), .start(start_3),
      .param_a(pa), .param_b(pb), .param_c(pc), .param_d(pd),
      .ready(ready_3), .load_mode(lm_3), .serial_data(sd_3), .done(done_3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // One enabled cycle as seen on the pins of instance idx.
   task automatic mon_step(input int idx, input int bc, input logic lm, input logic sd,
                           input logic dn, input logic rdy);
      exp_t        e;
      logic [23:0] got;
      bit          held;
      if (lm) begin
         if (!in_frame[idx]) begin
            in_frame[idx] = 1'b1;
            bq[idx].delete();
            if (sbq[idx].size() == 0) check("unexpected_frame", 1, 0);
            else if (sbq[idx][0].b2b) check("b2b_gap", gap[idx], 1);
         end
         check("ready_in_frame", rdy, 0);
         check("done_in_frame", dn, 0);
         bq[idx].push_back(sd);
      end else if (in_frame[idx]) begin
         in_frame[idx] = 1'b0;
         gap[idx] = 1;
         check("ready_after_frame", rdy, 1);
         if (dn) done_cnt[idx]++;
         if (sbq[idx].size() != 0) begin
            e = sbq[idx].pop_front();
            if (e.abort) begin
               check("abort_no_done", dn, 0);
               check("abort_partial", bq[idx].size() < 24 * bc, 1);
            end else begin
               check("frame_done", dn, 1);
               check("frame_len", bq[idx].size(), 24 * bc);
               if (bq[idx].size() == 24 * bc) begin
                  held = 1'b1;
                  for (int k = 0; k < 24; k++) begin
                     got[23-k] = bq[idx][k*bc];
                     for (int j = 1; j < bc; j++)
                        if (bq[idx][k*bc+j] != bq[idx][k*bc]) held = 1'b0;
                  end
                  check("bit_hold", held, 1);
                  check("frame_data", got, e.frame);
               end
            end
         end
      end else begin
         gap[idx]++;
         check("idle_done", dn, 0);
         check("idle_ready", rdy, 1);
         check("idle_data", sd, 0);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on && enable) begin
         mon_step(0, 1, lm_1, sd_1, done_1, ready_1);
         mon_step(1, 3, lm_3, sd_3, done_3, ready_3);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int idx);
      int i;
      for (i = 0; i < 400; i++) begin
         if ((idx == 0) ? ready_1 : ready_3) break;
         tick(1);
      end
      if (i == 400) check("ready_timeout", 0, 1);
   endtask

   function automatic exp_t mk(input logic [5:0] a, b, c, d, input bit ab, input bit b2);
      exp_t e;
      e.frame = {a, b, c, d};
      e.abort = ab;
      e.b2b   = b2;
      return e;
   endfunction

   // Waits for idle, presents the parameters with a one-cycle start; returns just after the accepting edge.
   task automatic send(input int idx, input logic [5:0] a, b, c, d, input bit ab);
      wait_ready(idx);
      pa = a; pb = b; pc = c; pd = d;
      if (idx == 0) start_1 = 1'b1; else start_3 = 1'b1;
      sbq[idx].push_back(mk(a, b, c, d, ab, 1'b0));
      tick(1);
      start_1 = 1'b0;
      start_3 = 1'b0;
   endtask

   function automatic logic [5:0] rnd6();
      return 6'($urandom_range(0, 63));
   endfunction

   initial begin
      logic [5:0]  a, b, c, d;
      logic [23:0] fr;
      int          n, dc;

      reset = 1'b1; enable = 1'b1; start_1 = 1'b0; start_3 = 1'b0;
      pa = '0; pb = '0; pc = '0; pd = '0;
      tick(3);
      reset = 1'b0;
      check("rst_ready", ready_1, 1);
      check("rst_load_mode", lm_1, 0);
      check("rst_serial", sd_1, 0);
      check("rst_done", done_1, 0);
      check("rst_ready3", ready_3, 1);
      mon_on = 1'b1;
      tick(2);

      // Directed pattern 101010_010101_111111_000000.
      send(0, 6'h2A, 6'h15, 6'h3F, 6'h00, 1'b0);
      check("first_bit", sd_1, 1);
      check("first_load_mode", lm_1, 1);
      wait_ready(0);
      check("done_pulse", done_1, 1);
      tick(3);

      // Slow instance: lone a[0] makes stream bit 5 high for three cycles.
      send(1, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0);
      wait_ready(1);
      tick(3);

      // Start pulsed and parameters scrambled mid-frame.
      dc = done_cnt[0];
      send(0, rnd6(), rnd6(), rnd6(), rnd6(), 1'b0);
      tick(5);
      pa = rnd6(); pb = rnd6(); start_1 = 1'b1;
      tick(1);
      start_1 = 1'b0;
      tick(3);
      pc = rnd6(); pd = rnd6();
      wait_ready(0);
      tick(4);
      check("single_done", done_cnt[0] - dc, 1);

      // Back-to-back frames with start held high.
      a = rnd6(); b = rnd6(); c = rnd6(); d = rnd6();
      wait_ready(0);
      pa = a; pb = b; pc = c; pd = d;
      start_1 = 1'b1;
      sbq[0].push_back(mk(a, b, c, d, 1'b0, 1'b0));
      tick(1);
      a = rnd6(); b = rnd6(); c = rnd6(); d = rnd6();
      pa = a; pb = b; pc = c; pd = d;
      sbq[0].push_back(mk(a, b, c, d, 1'b0, 1'b1));
      wait_ready(0);
      tick(1);
      start_1 = 1'b0;
      wait_ready(0);
      tick(3);

      // Enable low for five cycles while bit 10 is on the line.
      a = rnd6(); b = rnd6(); c = rnd6(); d = rnd6();
      fr = {a, b, c, d};
      send(0, a, b, c, d, 1'b0);
      tick(10);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("frozen_data", sd_1, fr[13]);
         check("frozen_load_mode", lm_1, 1);
         tick(1);
      end
      enable = 1'b1;
      n = 15;
      while (!done_1 && n < 200) begin
         tick(1);
         n++;
      end
      check("done_delay", n, 29);
      tick(3);

      // Reset during bit 12 abandons the frame; a fresh frame follows.
      send(0, rnd6(), rnd6(), rnd6(), rnd6(), 1'b1);
      sbq[0][sbq[0].size()-1].abort = 1'b1;
      tick(12);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("mid_rst_load_mode", lm_1, 0);
      check("mid_rst_ready", ready_1, 1);
      check("mid_rst_done", done_1, 0);
      tick(3);
      send(0, rnd6(), rnd6(), rnd6(), rnd6(), 1'b0);
      wait_ready(0);

      // Random frames on both instances.
      for (int i = 0; i < 4; i++) begin
         send(0, rnd6(), rnd6(), rnd6(), rnd6(), 1'b0);
         wait_ready(0);
         send(1, rnd6(), rnd6(), rnd6(), rnd6(), 1'b0);
         wait_ready(1);
         tick($urandom_range(1, 4));
      end
      tick(5);
      check("sb_empty_1", sbq[0].size(), 0);
      check("sb_empty_3", sbq[1].size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
